// File: rtl/rf_read_arbiter_pkg.sv
// Shared types and defaults for the register-file read-port arbiter.
// RF_ARB_LOCK_EN (defined elsewhere) enables the burst-lock FSM in the arbiter.
package rf_arb_pkg;

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int unsigned RF_ARB_NREQ = 2;
    localparam int unsigned RF_ARB_AW   = 8;
    localparam int unsigned RF_ARB_DW   = 8;

    // Index width for a requester count; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_read_arbiter_if.sv
// Requester/register-file bundle for rf_read_arbiter.
// The lock vector exists only when RF_ARB_LOCK_EN is defined.
interface rf_read_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int unsigned NREQ = RF_ARB_NREQ,
    parameter int unsigned AW   = RF_ARB_AW,
    parameter int unsigned DW   = RF_ARB_DW
);

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
`ifdef RF_ARB_LOCK_EN
    logic [NREQ-1:0]    lock;
`endif
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               rf_ren;
    logic [AW-1:0]      rf_raddr;
    logic [DW-1:0]      rf_rdata;

`ifdef RF_ARB_LOCK_EN
    modport slave (
        input  req, addr, lock, rf_rdata,
        output gnt, rvalid, rdata, rf_ren, rf_raddr
    );
    modport master (
        output req, addr, lock, rf_rdata,
        input  gnt, rvalid, rdata, rf_ren, rf_raddr
    );
`else
    modport slave (
        input  req, addr, rf_rdata,
        output gnt, rvalid, rdata, rf_ren, rf_raddr
    );
    modport master (
        output req, addr, rf_rdata,
        input  gnt, rvalid, rdata, rf_ren, rf_raddr
    );
`endif

endinterface

// File: rtl/rf_read_arbiter_rr_pick.sv
// Rotating priority encoder: first set request scanning upward from ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);

    int unsigned cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter for the single read port of the register file.
// Define RF_ARB_LOCK_EN to add the lock input and the ARB/LOCKED burst FSM.
module rf_read_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned NREQ = RF_ARB_NREQ,
    parameter int unsigned AW   = RF_ARB_AW,
    parameter int unsigned DW   = RF_ARB_DW
) (
    input  logic               Clk,
    input  logic               Rst,
    rf_read_arbiter_if.slave   bus
);

    localparam int unsigned PW = ptr_width(NREQ);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] gnt_int;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rvalid_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req  (bus.req),
        .ptr  (ptr),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef RF_ARB_LOCK_EN
    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] owner;
    logic [PW-1:0] owner_nxt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ST_ARB;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        gnt_int   = '0;
        gnt_idx   = '0;
        unique case (state)
            ST_ARB: begin
                if (pick_any) begin
                    gnt_int = pick_gnt;
                    gnt_idx = pick_idx;
                    ptr_nxt = wrap_inc(pick_idx);
                    if (bus.lock[pick_idx]) begin
                        state_nxt = ST_LOCKED;
                        owner_nxt = pick_idx;
                    end
                end
            end
            ST_LOCKED: begin
                // Final grant with lock low and release happen together; abandon grants nothing.
                if (bus.req[owner]) begin
                    gnt_int[owner] = 1'b1;
                    gnt_idx        = owner;
                    if (!bus.lock[owner]) begin
                        state_nxt = ST_ARB;
                        ptr_nxt   = wrap_inc(owner);
                    end
                end else begin
                    state_nxt = ST_ARB;
                    ptr_nxt   = wrap_inc(owner);
                end
            end
            default: state_nxt = ST_ARB;
        endcase
    end
`else
    always_comb begin
        gnt_int = pick_gnt;
        gnt_idx = pick_idx;
        ptr_nxt = pick_any ? wrap_inc(pick_idx) : ptr;
    end
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ptr      <= '0;
            rvalid_q <= '0;
        end else begin
            ptr      <= ptr_nxt;
            rvalid_q <= gnt;
        end
    end

    // Grant is suppressed for the whole time reset is held, whatever req shows.
    always_comb begin
        gnt = Rst ? gnt_int : '0;
    end

    always_comb begin
        bus.gnt      = gnt;
        bus.rf_ren   = |gnt;
        bus.rf_raddr = (|gnt) ? bus.addr[int'(gnt_idx)*AW +: AW] : '0;
        bus.rvalid   = rvalid_q;
        bus.rdata    = bus.rf_rdata;
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Scoreboard bench for rf_read_arbiter with a registered register-file model.
// Lock scenarios are included when RF_ARB_LOCK_EN is defined.
module tb_rf_read_arbiter;

    logic clk;
    logic rst;
    logic [1:0] lock_drv;

    rf_read_arbiter_if #(.NREQ(2), .AW(8), .DW(8)) bus ();

    rf_read_arbiter #(.NREQ(2), .AW(8), .DW(8)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

`ifdef RF_ARB_LOCK_EN
    assign bus.lock = lock_drv;
`endif

    typedef struct {
        logic [1:0] g;
        logic [7:0] v;
    } exp_t;

    exp_t gnt_q[$];
    exp_t rd_q[$];
    exp_t e_g;
    exp_t e_r;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (bus.rf_ren) bus.rf_rdata <= pat(bus.rf_raddr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.rf_ren) begin
                if (gnt_q.size() == 0) check("gnt_unexpected", 32'(bus.gnt), 32'd0);
                else begin
                    e_g = gnt_q.pop_front();
                    check("gnt", 32'(bus.gnt), 32'(e_g.g));
                    check("raddr", 32'(bus.rf_raddr), 32'(e_g.v));
                end
            end
            if (bus.rvalid != 2'b00) begin
                if (rd_q.size() == 0) check("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
                else begin
                    e_r = rd_q.pop_front();
                    check("rvalid", 32'(bus.rvalid), 32'(e_r.g));
                    check("rdata", 32'(bus.rdata), 32'(e_r.v));
                end
            end
        end
    end

    task automatic step(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] a1,
                        input logic [1:0] lk, input logic [1:0] eg, input logic [7:0] ea,
                        input bit rd);
        @(posedge clk);
        #1;
        bus.req  = r;
        bus.addr = {a1, a0};
        lock_drv = lk;
        if (eg != 2'b00) begin
            gnt_q.push_back('{eg, ea});
            if (rd) rd_q.push_back('{eg, pat(ea)});
        end else begin
            #1;
            check("idle_gnt", 32'(bus.gnt), 32'd0);
            check("idle_ren", 32'(bus.rf_ren), 32'd0);
            check("idle_raddr", 32'(bus.rf_raddr), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.req  = '0;
        lock_drv = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        bus.req  = '0;
        bus.addr = '0;
        lock_drv = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.req = 2'b11;
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_ren", 32'(bus.rf_ren), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        bus.req = '0;

        // single request
        step(2'b01, 8'h05, 8'h00, 2'b00, 2'b01, 8'h05, 1'b1);
        step(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);
        do_reset();

        // contention from reset
        step(2'b11, 8'h20, 8'h30, 2'b00, 2'b01, 8'h20, 1'b1);
        step(2'b11, 8'h21, 8'h31, 2'b00, 2'b10, 8'h31, 1'b1);
        step(2'b11, 8'h22, 8'h32, 2'b00, 2'b01, 8'h22, 1'b1);
        step(2'b11, 8'h23, 8'h33, 2'b00, 2'b10, 8'h33, 1'b1);

        // idle: nothing granted, pointer must hold at 0
        step(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);
        step(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);
        check("idle_rvalid", 32'(bus.rvalid), 32'd0);
        step(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);
        check("idle_rvalid", 32'(bus.rvalid), 32'd0);
        step(2'b11, 8'h24, 8'h34, 2'b00, 2'b01, 8'h24, 1'b1);
        step(2'b11, 8'h25, 8'h35, 2'b00, 2'b10, 8'h35, 1'b1);
        step(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);

        // reset mid-read: grant to 0 leaves ptr at 1, reset must clear it
        step(2'b01, 8'h07, 8'h00, 2'b00, 2'b01, 8'h07, 1'b0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        bus.req = '0;
        #1;
        check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        check("midrst_gnt", 32'(bus.gnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(2'b11, 8'h08, 8'h40, 2'b00, 2'b01, 8'h08, 1'b1);
        step(2'b10, 8'h08, 8'h41, 2'b00, 2'b10, 8'h41, 1'b1);
        step(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);

`ifdef RF_ARB_LOCK_EN
        do_reset();
        step(2'b01, 8'h50, 8'h00, 2'b00, 2'b01, 8'h50, 1'b1);
        // burst of four by requester 1 while requester 0 waits
        step(2'b11, 8'h51, 8'h10, 2'b10, 2'b10, 8'h10, 1'b1);
        step(2'b11, 8'h51, 8'h11, 2'b10, 2'b10, 8'h11, 1'b1);
        step(2'b11, 8'h51, 8'h12, 2'b10, 2'b10, 8'h12, 1'b1);
        step(2'b11, 8'h51, 8'h13, 2'b00, 2'b10, 8'h13, 1'b1);
        step(2'b01, 8'h51, 8'h00, 2'b00, 2'b01, 8'h51, 1'b1);
        // abandon: owner drops req, req0 is ignored that cycle
        step(2'b10, 8'h00, 8'h60, 2'b10, 2'b10, 8'h60, 1'b1);
        step(2'b01, 8'h61, 8'h00, 2'b10, 2'b00, 8'h00, 1'b0);
        step(2'b11, 8'h62, 8'h63, 2'b00, 2'b01, 8'h62, 1'b1);
        step(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            if (gnt_q.size() == 0 && rd_q.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
